// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS-subset control FSM.
// Holds the opcode constants, the controller state encoding, the ALU and
// PC mux select encodings, the bundled control word and small decode helpers.
// No ports: imported by the interface, the timer and the top-level FSM.
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    RTEXE  = 4'd3,
    RTWB   = 4'd4,
    MEMADR = 4'd5,
    MEMRD  = 4'd6,
    MEMWB  = 4'd7,
    MEMWR  = 4'd8,
    BEQ    = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  // One bundle for every control output so the output decode can clear all
  // of them with a single default assignment.
  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    logic    iord;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    mem_to_reg;
    logic    reg_dst;
    logic    reg_write;
    logic    alu_src_a;
    srcb_t   alu_src_b;
    alu_op_t alu_op;
    pcsrc_t  pc_source;
    logic    retire;
  } ctrl_t;

  // States that wait on the memory handshake and are guarded by the timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bus between the control FSM and the datapath/memory.
// Inputs to the FSM: Opcode (IR[31:26]), Zero (ALU flag), MemReady.
// Outputs of the FSM: PC/IR/regfile/memory enables, mux selects, ALUOp,
// Retire pulse, InstrCount, and the sticky IllegalOp / MemTimeout flags.
// master = controller side, slave = datapath side.
interface multicycle_control_fsm_if
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic [OPCODE_W-1:0] Opcode;
  logic                Zero;
  logic                MemReady;

  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemtoReg;
  logic                RegDst;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic [1:0]          PCSource;
  logic                Retire;
  logic [CNT_W-1:0]    InstrCount;
  logic                IllegalOp;
  logic                MemTimeout;

  modport master (
    input  Opcode, Zero, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Retire, InstrCount, IllegalOp, MemTimeout
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Retire, InstrCount, IllegalOp, MemTimeout
  );

endinterface

// File: rtl/multicycle_control_fsm_timer.sv
// mem_wait_timer: counts cycles spent waiting for MemReady in one memory state.
// Ports: clk, rst_n (synchronous, active-low), clear (restart from zero),
// count (one more waiting cycle), expired (this is the TIMEOUT-th waiting
// cycle). TIMEOUT = 0 disables expiry entirely.
module mem_wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // The counter holds the number of cycles already waited, so the cycle in
  // which it equals TIMEOUT-1 is the last one allowed.
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] timer_r;

  // Wait-cycle counter; wraps harmlessly when expiry is disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_r <= '0;
    end else if (clear) begin
      timer_r <= '0;
    end else if (count) begin
      timer_r <= timer_r + CW'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

  assign expired = (TIMEOUT != 0) && (timer_r == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main control FSM of the multicycle MIPS-subset CPU.
// Ports: Clk, Rst_n (synchronous, active-low), bus (master modport) carrying
// Opcode/Zero/MemReady in and all datapath control signals out, plus the
// Retire pulse, the wrapping InstrCount and the sticky IllegalOp/MemTimeout.
// Control outputs are decoded from the state (IRWrite/PCWrite/Retire in the
// memory states also depend on MemReady) and are forced low while Rst_n=0.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  multicycle_control_fsm_if.master bus
);

  state_t           state_r;
  state_t           state_nxt_s;
  ctrl_t            ctl_s;
  logic             wait_s;
  logic             stay_s;
  logic             abort_s;
  logic             expired_s;
  logic             illegal_s;
  logic [CNT_W-1:0] instr_count_r;
  logic             illegal_r;
  logic             mem_timeout_r;

  assign wait_s    = is_wait_state(state_r);
  // MemReady wins over an expiring timer in the same cycle.
  assign stay_s    = wait_s && !bus.MemReady && !expired_s;
  assign abort_s   = wait_s && !bus.MemReady && expired_s;
  assign illegal_s = (state_r == DECODE) && !is_legal_op(bus.Opcode);

  // Leaving a wait state (or never being in one) restarts the timer, so it
  // is always zero on entry to FETCH/MEMRD/MEMWR, including FETCH re-entry.
  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .clear   (!stay_s),
    .count   (stay_s),
    .expired (expired_s)
  );

  // State register, retired-instruction counter and sticky error flags.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r       <= IDLE;
      instr_count_r <= '0;
      illegal_r     <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (ctl_s.retire) begin
        instr_count_r <= instr_count_r + CNT_W'(1);
      end else begin
        instr_count_r <= instr_count_r;
      end
      illegal_r     <= illegal_r | illegal_s;
      mem_timeout_r <= mem_timeout_r | abort_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:   state_nxt_s = FETCH;
      FETCH: begin
        // A timed-out fetch simply re-enters FETCH with a fresh timer.
        if (bus.MemReady) begin
          state_nxt_s = DECODE;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DECODE: begin
        case (bus.Opcode)
          OP_RTYPE:     state_nxt_s = RTEXE;
          OP_LW, OP_SW: state_nxt_s = MEMADR;
          OP_BEQ:       state_nxt_s = BEQ;
          OP_J:         state_nxt_s = JUMP;
          OP_ADDI:      state_nxt_s = ADDIEX;
          default:      state_nxt_s = FETCH;
        endcase
      end
      RTEXE:  state_nxt_s = RTWB;
      RTWB:   state_nxt_s = FETCH;
      MEMADR: begin
        if (bus.Opcode == OP_LW) begin
          state_nxt_s = MEMRD;
        end else begin
          state_nxt_s = MEMWR;
        end
      end
      MEMRD: begin
        if (bus.MemReady) begin
          state_nxt_s = MEMWB;
        end else if (expired_s) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = MEMRD;
        end
      end
      MEMWB:  state_nxt_s = FETCH;
      MEMWR: begin
        if (bus.MemReady || expired_s) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = MEMWR;
        end
      end
      BEQ:    state_nxt_s = FETCH;
      JUMP:   state_nxt_s = FETCH;
      ADDIEX: state_nxt_s = ADDIWB;
      ADDIWB: state_nxt_s = FETCH;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode; everything is held low during reset so no write enable
  // escapes in the cycle that aborts an instruction.
  always_comb begin
    ctl_s = '0;
    if (Rst_n) begin
      case (state_r)
        IDLE: ctl_s = '0;
        FETCH: begin
          ctl_s.mem_read  = 1'b1;
          ctl_s.alu_src_b = SRCB_FOUR;
          ctl_s.alu_op    = ALUOP_ADD;
          ctl_s.pc_source = PCSRC_ALU;
          ctl_s.ir_write  = bus.MemReady;
          ctl_s.pc_write  = bus.MemReady;
        end
        DECODE: begin
          ctl_s.alu_src_b = SRCB_IMM_SH;
          ctl_s.alu_op    = ALUOP_ADD;
          ctl_s.retire    = illegal_s;
        end
        RTEXE: begin
          ctl_s.alu_src_a = 1'b1;
          ctl_s.alu_src_b = SRCB_REG;
          ctl_s.alu_op    = ALUOP_FUNCT;
        end
        RTWB: begin
          ctl_s.reg_dst   = 1'b1;
          ctl_s.reg_write = 1'b1;
          ctl_s.retire    = 1'b1;
        end
        MEMADR, ADDIEX: begin
          ctl_s.alu_src_a = 1'b1;
          ctl_s.alu_src_b = SRCB_IMM;
          ctl_s.alu_op    = ALUOP_ADD;
        end
        MEMRD: begin
          ctl_s.mem_read = 1'b1;
          ctl_s.iord     = 1'b1;
        end
        MEMWB: begin
          ctl_s.mem_to_reg = 1'b1;
          ctl_s.reg_write  = 1'b1;
          ctl_s.retire     = 1'b1;
        end
        MEMWR: begin
          ctl_s.mem_write = 1'b1;
          ctl_s.iord      = 1'b1;
          ctl_s.retire    = bus.MemReady;
        end
        BEQ: begin
          ctl_s.alu_src_a     = 1'b1;
          ctl_s.alu_src_b     = SRCB_REG;
          ctl_s.alu_op        = ALUOP_SUB;
          ctl_s.pc_write_cond = 1'b1;
          ctl_s.pc_source     = PCSRC_ALUOUT;
          ctl_s.retire        = 1'b1;
        end
        JUMP: begin
          ctl_s.pc_write  = 1'b1;
          ctl_s.pc_source = PCSRC_JUMP;
          ctl_s.retire    = 1'b1;
        end
        ADDIWB: begin
          ctl_s.reg_write = 1'b1;
          ctl_s.retire    = 1'b1;
        end
        default: ctl_s = '0;
      endcase
    end else begin
      ctl_s = '0;
    end
  end

  assign bus.PCWrite     = ctl_s.pc_write;
  assign bus.PCWriteCond = ctl_s.pc_write_cond;
  assign bus.IorD        = ctl_s.iord;
  assign bus.MemRead     = ctl_s.mem_read;
  assign bus.MemWrite    = ctl_s.mem_write;
  assign bus.IRWrite     = ctl_s.ir_write;
  assign bus.MemtoReg    = ctl_s.mem_to_reg;
  assign bus.RegDst      = ctl_s.reg_dst;
  assign bus.RegWrite    = ctl_s.reg_write;
  assign bus.ALUSrcA     = ctl_s.alu_src_a;
  assign bus.ALUSrcB     = ctl_s.alu_src_b;
  assign bus.ALUOp       = ctl_s.alu_op;
  assign bus.PCSource    = ctl_s.pc_source;
  assign bus.Retire      = ctl_s.retire;
  assign bus.InstrCount  = instr_count_r;
  assign bus.IllegalOp   = illegal_r;
  assign bus.MemTimeout  = mem_timeout_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. An instruction-level model
// (step number within the current instruction, instruction length per opcode,
// waited-cycle count) predicts every output each cycle under directed and
// $urandom stimulus. CNT_W is 4 so the counter wrap is reachable.
module tb_multicycle_control_fsm;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_ADDI = 6'b001000;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [5:0] in_op;
  logic       in_rdy;
  logic       in_zero;

  int         n_tests = 0;
  int         n_fail  = 0;

  // reference model state
  int         m_step;   // 0 idle, 1 fetch, 2 decode, 3.. per-instruction steps
  int         m_wait;
  int         m_cnt;
  logic [5:0] m_op;
  logic       m_ill;
  logic       m_to;

  logic [5:0] legal_ops [6] = '{OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_J, OPC_ADDI};

  always #5 Clk = ~Clk;

  multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();

  assign bus.Opcode   = in_op;
  assign bus.MemReady = in_rdy;
  assign bus.Zero     = in_zero;

  multicycle_control_fsm #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Total cycles of an instruction with no memory wait.
  function automatic int instr_len(input logic [5:0] op);
    case (op)
      OPC_R, OPC_SW, OPC_ADDI: return 4;
      OPC_LW:                  return 5;
      OPC_BEQ, OPC_J:          return 3;
      default:                 return 2;
    endcase
  endfunction

  function automatic logic waiting(input int step, input logic [5:0] op);
    return (step == 1) || (step == 4 && (op == OPC_LW || op == OPC_SW));
  endfunction

  // Expected {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
  //           RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,Retire}
  function automatic logic [16:0] exp_ctl(input int step, input logic [5:0] op,
                                          input logic rdy, input logic rstn);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ret;
    logic [1:0] srcb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ret} = 11'd0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    if (rstn && step == 1) begin
      mrd = 1'b1; srcb = 2'b01; irw = rdy; pcw = rdy;
    end else if (rstn && step == 2) begin
      srcb = 2'b11; ret = !legal(op);
    end else if (rstn && step >= 3) begin
      case (op)
        OPC_R:    if (step == 3) begin srca = 1'b1; aop = 2'b10; end
                  else begin rdst = 1'b1; rw = 1'b1; ret = 1'b1; end
        OPC_LW:   if (step == 3) begin srca = 1'b1; srcb = 2'b10; end
                  else if (step == 4) begin mrd = 1'b1; iord = 1'b1; end
                  else begin m2r = 1'b1; rw = 1'b1; ret = 1'b1; end
        OPC_SW:   if (step == 3) begin srca = 1'b1; srcb = 2'b10; end
                  else begin mwr = 1'b1; iord = 1'b1; ret = rdy; end
        OPC_BEQ:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; ret = 1'b1; end
        OPC_J:    begin pcw = 1'b1; psrc = 2'b10; ret = 1'b1; end
        OPC_ADDI: if (step == 3) begin srca = 1'b1; srcb = 2'b10; end
                  else begin rw = 1'b1; ret = 1'b1; end
        default:  ret = 1'b0;
      endcase
    end
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc, ret};
  endfunction

  task automatic advance(input logic [5:0] op, input logic ret);
    if (!Rst_n) begin
      m_step = 0; m_wait = 0; m_cnt = 0; m_ill = 1'b0; m_to = 1'b0;
    end else begin
      if (ret) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (m_step == 0) begin
        m_step = 1;
      end else if (waiting(m_step, op) && !in_rdy) begin
        if (TIMEOUT != 0 && m_wait + 1 >= TIMEOUT) begin
          m_to = 1'b1; m_step = 1; m_wait = 0;
        end else begin
          m_wait++;
        end
      end else begin
        m_wait = 0;
        if (m_step == 2) begin
          m_op = op;
          if (!legal(op)) m_ill = 1'b1;
        end
        m_step = (m_step >= instr_len(op)) ? 1 : m_step + 1;
      end
    end
  endtask

  // One clock: entered at posedge+1 with inputs set, compares mid-cycle.
  task automatic cycle(output logic ret_seen);
    logic [5:0]  cur_op;
    logic [16:0] exp_v, got_v;
    #3;
    cur_op = (m_step >= 3) ? m_op : in_op;
    exp_v  = exp_ctl(m_step, cur_op, in_rdy, Rst_n);
    got_v  = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
              bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
              bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.Retire};
    check($sformatf("ctl_step%0d_op%02h", m_step, cur_op), 32'(got_v), 32'(exp_v));
    check("instr_count", 32'(bus.InstrCount), 32'(m_cnt));
    check("illegal_op", 32'(bus.IllegalOp), 32'(m_ill));
    check("mem_timeout", 32'(bus.MemTimeout), 32'(m_to));
    ret_seen = bus.Retire;
    advance(cur_op, exp_v[0]);
    @(posedge Clk);
    #1;
  endtask

  // Runs one instruction from FETCH and checks its length in cycles.
  task automatic run_instr(input logic [5:0] op, input int mem_waits,
                           input int exp_lat, input string tag);
    int   n  = 0;
    int   mw = 0;
    logic r  = 1'b0;
    in_op   = op;
    in_zero = 1'b1;
    while (!r && n < 40) begin
      if (m_step == 4 && mw < mem_waits) begin
        in_rdy = 1'b0; mw++;
      end else begin
        in_rdy = 1'b1;
      end
      n++;
      cycle(r);
    end
    check(tag, 32'(n), 32'(exp_lat));
  endtask

  function automatic logic [5:0] pick_op(input logic allow_ill);
    if (allow_ill && $urandom_range(0, 9) == 0) return 6'($urandom_range(0, 63));
    return legal_ops[$urandom_range(0, 5)];
  endfunction

  task automatic do_reset();
    logic r;
    Rst_n = 1'b0;
    cycle(r);
    cycle(r);
    Rst_n = 1'b1;
    in_rdy = 1'b1;
    cycle(r);   // IDLE
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic r;
    Rst_n = 1'b0; in_op = OPC_R; in_rdy = 1'b0; in_zero = 1'b0;
    m_step = 0; m_wait = 0; m_cnt = 0; m_op = OPC_R; m_ill = 1'b0; m_to = 1'b0;
    @(posedge Clk);
    #1;
    do_reset();
    check("fetch_after_release_memread", 32'(bus.MemRead), 32'd1);
    check("fetch_after_release_iord", 32'(bus.IorD), 32'd0);

    // directed instruction latencies
    run_instr(OPC_R,    0, 4, "lat_rtype");
    run_instr(OPC_LW,   3, 8, "lat_lw_wait3");
    run_instr(OPC_LW,   0, 5, "lat_lw");
    run_instr(OPC_SW,   0, 4, "lat_sw");
    run_instr(OPC_SW,   2, 6, "lat_sw_wait2");
    run_instr(OPC_BEQ,  0, 3, "lat_beq");
    run_instr(OPC_J,    0, 3, "lat_jump");
    run_instr(OPC_ADDI, 0, 4, "lat_addi");
    check("count_after_directed", 32'(bus.InstrCount), 32'd8);
    run_instr(6'b111111, 0, 2, "lat_illegal");
    check("illegal_set", 32'(bus.IllegalOp), 32'd1);
    run_instr(OPC_R, 0, 4, "lat_rtype_after_illegal");
    check("illegal_sticky", 32'(bus.IllegalOp), 32'd1);

    // fetch timeout: MemReady held low
    in_rdy = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) cycle(r);
    check("tmo_fetch_set", 32'(bus.MemTimeout), 32'd1);
    check("tmo_fetch_reenter", 32'(bus.MemRead), 32'd1);

    // reset in the middle of an R-type execute
    in_rdy = 1'b1; in_op = OPC_R;
    cycle(r);
    cycle(r);
    do_reset();
    check("rst_clears_illegal", 32'(bus.IllegalOp), 32'd0);
    check("rst_clears_timeout", 32'(bus.MemTimeout), 32'd0);
    check("rst_clears_count", 32'(bus.InstrCount), 32'd0);

    // lw whose read never completes
    in_op = OPC_LW; in_rdy = 1'b1;
    for (int i = 0; i < 10 && m_step != 4; i++) cycle(r);
    in_rdy = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) cycle(r);
    check("tmo_memrd_set", 32'(bus.MemTimeout), 32'd1);
    check("tmo_memrd_no_retire", 32'(bus.InstrCount), 32'd0);

    // counter wrap (CNT_W = 4)
    for (int i = 0; i < 17; i++) run_instr(OPC_J, 0, 3, "lat_jump_wrap");
    check("count_wrap", 32'(bus.InstrCount), 32'd1);

    // random: mostly-ready memory, legal opcodes
    for (int i = 0; i < 800; i++) begin
      if (m_step <= 1 && $urandom_range(0, 3) == 0) in_op = pick_op(1'b0);
      in_rdy  = ($urandom_range(0, 3) != 0);
      in_zero = 1'($urandom_range(0, 1));
      cycle(r);
    end
    // random: slow memory (timeouts likely), occasional illegal opcodes
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (m_step <= 1 && $urandom_range(0, 3) == 0) in_op = pick_op(1'b1);
      in_rdy  = ($urandom_range(0, 7) == 0);
      in_zero = 1'($urandom_range(0, 1));
      cycle(r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
